// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// State encoding is fixed so the values can be observed on a debug bus.
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      StRun     = 2'd0,
      StMemWait = 2'd1,
      StFault   = 2'd2
   } state_e;

   localparam logic [4:0] REG_X0 = 5'd0;

   // x0 is hardwired to zero, so a write to it can never create a dependency.
   function automatic logic reg_dep(input logic [4:0] rd, input logic [4:0] rs);
      return (rd != REG_X0) && (rd == rs);
   endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bus between the pipeline datapath and the hazard controller.
// master = controller side, slave = datapath side.
interface pipe_hazard_ctrl_if #(
   parameter int unsigned CNT_W = 32
);
   logic [4:0]       if_id_rs1;
   logic [4:0]       if_id_rs2;
   logic             id_ex_mem_read;
   logic [4:0]       id_ex_rd;
   logic             ex_mem_mem_rd;
   logic             ex_mem_mem_wr;
   logic             ex_mem_branch;
   logic             ex_mem_zero;
   logic             dmem_ready;

   logic             pc_write;
   logic             pc_sel_branch;
   logic             if_id_write;
   logic             if_id_flush;
   logic             id_ex_write;
   logic             id_ex_flush;
   logic             ex_mem_flush;
   logic             ex_mem_hold;
   logic             mem_wb_bubble;
   logic             dmem_req;
   logic             mem_fault;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   modport master (
      input  if_id_rs1, if_id_rs2, id_ex_mem_read, id_ex_rd, ex_mem_mem_rd,
             ex_mem_mem_wr, ex_mem_branch, ex_mem_zero, dmem_ready,
      output pc_write, pc_sel_branch, if_id_write, if_id_flush, id_ex_write,
             id_ex_flush, ex_mem_flush, ex_mem_hold, mem_wb_bubble, dmem_req,
             mem_fault, stall_cnt, flush_cnt
   );

   modport slave (
      output if_id_rs1, if_id_rs2, id_ex_mem_read, id_ex_rd, ex_mem_mem_rd,
             ex_mem_mem_wr, ex_mem_branch, ex_mem_zero, dmem_ready,
      input  pc_write, pc_sel_branch, if_id_write, if_id_flush, id_ex_write,
             id_ex_flush, ex_mem_flush, ex_mem_hold, mem_wb_bubble, dmem_req,
             mem_fault, stall_cnt, flush_cnt
   );
endinterface

// File: rtl/pipe_hazard_ctrl_mem_wait_timer.sv
// Counts cycles spent waiting on data memory; expired flags the timeout limit.
// start loads 1, busy advances the count, anything else clears it.
module mem_wait_timer #(
   parameter int unsigned MEM_TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic busy,
   output logic expired
);
   localparam int unsigned TW = $clog2(MEM_TIMEOUT + 1);

   logic [TW-1:0] cnt_q, cnt_d;

   assign expired = (cnt_q == TW'(MEM_TIMEOUT));

   always_comb begin
      cnt_d = '0;
      if (start) begin
         cnt_d = TW'(1);
      end else if (busy && !expired) begin
         cnt_d = cnt_q + TW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes, data-memory
// wait stalls with a sticky timeout fault, plus saturating stall/flush counters.
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter int unsigned CNT_W       = 32
) (
   input logic               clk,
   input logic               rst,
   pipe_hazard_ctrl_if.master bus
);
   state_e           state_q, state_d;
   logic             mem_fault_q;
   logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

   logic memop, taken, load_use, mem_stall;
   logic tmr_start, tmr_busy, tmr_expired;
   logic pc_write, pc_sel_branch, if_id_write, if_id_flush, id_ex_write;
   logic id_ex_flush, ex_mem_flush, ex_mem_hold, mem_wb_bubble, dmem_req;

   assign memop    = bus.ex_mem_mem_rd | bus.ex_mem_mem_wr;
   assign taken    = bus.ex_mem_branch & bus.ex_mem_zero;
   assign load_use = bus.id_ex_mem_read &
                     (reg_dep(bus.id_ex_rd, bus.if_id_rs1) |
                      reg_dep(bus.id_ex_rd, bus.if_id_rs2));

   // Full memory stall: a new unfinished access, an access still pending, or fault.
   always_comb begin
      unique case (state_q)
         StRun:     mem_stall = memop & ~bus.dmem_ready;
         StMemWait: mem_stall = ~bus.dmem_ready;
         default:   mem_stall = 1'b1;
      endcase
   end

   assign tmr_start = (state_q == StRun) & memop & ~bus.dmem_ready;
   assign tmr_busy  = (state_q == StMemWait) & ~bus.dmem_ready;

   mem_wait_timer #(
      .MEM_TIMEOUT(MEM_TIMEOUT)
   ) u_mem_wait_timer (
      .clk    (clk),
      .rst    (rst),
      .start  (tmr_start),
      .busy   (tmr_busy),
      .expired(tmr_expired)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StRun;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StRun: begin
            if (memop && !bus.dmem_ready) state_d = StMemWait;
         end
         StMemWait: begin
            if (bus.dmem_ready) begin
               state_d = StRun;
            end else if (tmr_expired) begin
               state_d = StFault;
            end
         end
         default: state_d = StFault;
      endcase
   end

   always_comb begin
      pc_write      = 1'b1;
      pc_sel_branch = 1'b0;
      if_id_write   = 1'b1;
      if_id_flush   = 1'b0;
      id_ex_write   = 1'b1;
      id_ex_flush   = 1'b0;
      ex_mem_flush  = 1'b0;
      ex_mem_hold   = 1'b0;
      mem_wb_bubble = 1'b0;
      dmem_req      = memop & (state_q != StFault);
      if (mem_stall) begin
         pc_write      = 1'b0;
         if_id_write   = 1'b0;
         id_ex_write   = 1'b0;
         ex_mem_hold   = 1'b1;
         mem_wb_bubble = 1'b1;
      end else if (taken) begin
         pc_sel_branch = 1'b1;
         if_id_flush   = 1'b1;
         id_ex_flush   = 1'b1;
         ex_mem_flush  = 1'b1;
      end else if (load_use) begin
         pc_write    = 1'b0;
         if_id_write = 1'b0;
         id_ex_flush = 1'b1;
      end
      // Reset presents a fully flushed, frozen pipeline with no memory request.
      if (rst) begin
         pc_write      = 1'b0;
         pc_sel_branch = 1'b0;
         if_id_write   = 1'b0;
         if_id_flush   = 1'b1;
         id_ex_write   = 1'b0;
         id_ex_flush   = 1'b1;
         ex_mem_flush  = 1'b1;
         ex_mem_hold   = 1'b0;
         mem_wb_bubble = 1'b1;
         dmem_req      = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_fault_q <= 1'b0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (tmr_busy && tmr_expired) mem_fault_q <= 1'b1;
         if (!pc_write && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 1'b1;
         if (!mem_stall && taken && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 1'b1;
      end
   end

   assign bus.pc_write      = pc_write;
   assign bus.pc_sel_branch = pc_sel_branch;
   assign bus.if_id_write   = if_id_write;
   assign bus.if_id_flush   = if_id_flush;
   assign bus.id_ex_write   = id_ex_write;
   assign bus.id_ex_flush   = id_ex_flush;
   assign bus.ex_mem_flush  = ex_mem_flush;
   assign bus.ex_mem_hold   = ex_mem_hold;
   assign bus.mem_wb_bubble = mem_wb_bubble;
   assign bus.dmem_req      = dmem_req;
   assign bus.mem_fault     = mem_fault_q;
   assign bus.stall_cnt     = stall_cnt_q;
   assign bus.flush_cnt     = flush_cnt_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with MEM_TIMEOUT=4 and 4-bit counters.
module tb_pipe_hazard_ctrl;
   localparam int unsigned CNT_W = 4;

   // {pc_write, pc_sel_branch, if_id_write, if_id_flush, id_ex_write,
   //  id_ex_flush, ex_mem_flush, ex_mem_hold, mem_wb_bubble, dmem_req}
   localparam logic [9:0] CTL_DEF     = 10'b1010100000;
   localparam logic [9:0] CTL_DEF_REQ = 10'b1010100001;
   localparam logic [9:0] CTL_RST     = 10'b0001011010;
   localparam logic [9:0] CTL_MSTALL  = 10'b0000000111;
   localparam logic [9:0] CTL_FAULT   = 10'b0000000110;
   localparam logic [9:0] CTL_BRANCH  = 10'b1111111000;
   localparam logic [9:0] CTL_LDUSE   = 10'b0000110000;

   logic clk = 1'b0;
   logic rst;
   int   err_cnt = 0;
   int   chk_cnt = 0;

   pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

   pipe_hazard_ctrl #(
      .MEM_TIMEOUT(4),
      .CNT_W      (CNT_W)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   logic [9:0] ctl;
   assign ctl = {bus.pc_write, bus.pc_sel_branch, bus.if_id_write, bus.if_id_flush,
                 bus.id_ex_write, bus.id_ex_flush, bus.ex_mem_flush, bus.ex_mem_hold,
                 bus.mem_wb_bubble, bus.dmem_req};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      chk_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.if_id_rs1      = 5'd0;
      bus.if_id_rs2      = 5'd0;
      bus.id_ex_mem_read = 1'b0;
      bus.id_ex_rd       = 5'd0;
      bus.ex_mem_mem_rd  = 1'b0;
      bus.ex_mem_mem_wr  = 1'b0;
      bus.ex_mem_branch  = 1'b0;
      bus.ex_mem_zero    = 1'b0;
      bus.dmem_ready     = 1'b0;
   endtask

   initial begin
      clear_inputs();
      rst               = 1'b1;
      bus.ex_mem_mem_wr = 1'b1;
      #1;
      check("rst_ctl", 32'(ctl), 32'(CTL_RST));
      cycle();
      rst = 1'b0;
      bus.ex_mem_mem_wr = 1'b0;
      #1;
      check("reset_ctl", 32'(ctl), 32'(CTL_DEF));
      check("reset_fault", 32'(bus.mem_fault), 32'd0);
      check("reset_stall_cnt", 32'(bus.stall_cnt), 32'd0);
      check("reset_flush_cnt", 32'(bus.flush_cnt), 32'd0);

      // Load x5 in EX, ID reads x5 through rs1
      bus.id_ex_mem_read = 1'b1;
      bus.id_ex_rd       = 5'd5;
      bus.if_id_rs1      = 5'd5;
      #1;
      check("lduse_rs1_ctl", 32'(ctl), 32'(CTL_LDUSE));
      cycle();
      clear_inputs();
      #1;
      check("lduse_stall_cnt", 32'(bus.stall_cnt), 32'd1);
      check("lduse_after_ctl", 32'(ctl), 32'(CTL_DEF));

      // x0 destination never stalls; rs2 match does
      bus.id_ex_mem_read = 1'b1;
      #1;
      check("lduse_x0_ctl", 32'(ctl), 32'(CTL_DEF));
      bus.id_ex_rd  = 5'd7;
      bus.if_id_rs1 = 5'd3;
      bus.if_id_rs2 = 5'd7;
      #1;
      check("lduse_rs2_ctl", 32'(ctl), 32'(CTL_LDUSE));
      cycle();
      clear_inputs();
      #1;
      check("lduse_rs2_stall_cnt", 32'(bus.stall_cnt), 32'd2);

      // Taken branch overrides a concurrent load-use
      bus.id_ex_mem_read = 1'b1;
      bus.id_ex_rd       = 5'd9;
      bus.if_id_rs1      = 5'd9;
      bus.ex_mem_branch  = 1'b1;
      bus.ex_mem_zero    = 1'b1;
      #1;
      check("branch_ctl", 32'(ctl), 32'(CTL_BRANCH));
      cycle();
      clear_inputs();
      bus.ex_mem_branch = 1'b1;
      #1;
      check("branch_flush_cnt", 32'(bus.flush_cnt), 32'd1);
      check("branch_stall_cnt", 32'(bus.stall_cnt), 32'd2);
      check("branch_nottaken_ctl", 32'(ctl), 32'(CTL_DEF));
      cycle();
      clear_inputs();
      #1;
      check("nottaken_flush_cnt", 32'(bus.flush_cnt), 32'd1);

      // Store completing immediately
      bus.ex_mem_mem_wr = 1'b1;
      bus.dmem_ready    = 1'b1;
      #1;
      check("store_fast_ctl", 32'(ctl), 32'(CTL_DEF_REQ));
      cycle();

      // Store with ready after 3 stalled cycles
      bus.dmem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         check($sformatf("store_wait%0d_ctl", i), 32'(ctl), 32'(CTL_MSTALL));
         cycle();
      end
      bus.dmem_ready = 1'b1;
      #1;
      check("store_done_ctl", 32'(ctl), 32'(CTL_DEF_REQ));
      cycle();
      clear_inputs();
      #1;
      check("store_run_ctl", 32'(ctl), 32'(CTL_DEF));
      check("store_stall_cnt", 32'(bus.stall_cnt), 32'd5);

      // Reset pulse in the middle of a memory wait
      bus.ex_mem_mem_rd = 1'b1;
      #1;
      cycle();
      check("rstwait_pre_ctl", 32'(ctl), 32'(CTL_MSTALL));
      rst = 1'b1;
      #1;
      check("rstwait_rst_ctl", 32'(ctl), 32'(CTL_RST));
      cycle();
      rst = 1'b0;
      clear_inputs();
      #1;
      check("rstwait_run_ctl", 32'(ctl), 32'(CTL_DEF));
      check("rstwait_stall_cnt", 32'(bus.stall_cnt), 32'd0);
      check("rstwait_flush_cnt", 32'(bus.flush_cnt), 32'd0);
      check("rstwait_fault", 32'(bus.mem_fault), 32'd0);

      // Timeout: 5 stalled cycles then FAULT
      bus.ex_mem_mem_wr = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         check($sformatf("tmo_wait%0d_ctl", i), 32'(ctl), 32'(CTL_MSTALL));
         check($sformatf("tmo_wait%0d_fault", i), 32'(bus.mem_fault), 32'd0);
         cycle();
      end
      #1;
      check("fault_ctl", 32'(ctl), 32'(CTL_FAULT));
      check("fault_flag", 32'(bus.mem_fault), 32'd1);
      check("fault_stall_cnt", 32'(bus.stall_cnt), 32'd5);

      // Ready does not release FAULT; stall counter saturates
      bus.dmem_ready = 1'b1;
      for (int i = 0; i < 9; i++) cycle();
      check("fault_hold_ctl", 32'(ctl), 32'(CTL_FAULT));
      check("fault_stall_cnt14", 32'(bus.stall_cnt), 32'd14);
      cycle();
      check("stall_cnt_max", 32'(bus.stall_cnt), 32'd15);
      cycle();
      check("stall_cnt_sat", 32'(bus.stall_cnt), 32'd15);
      check("fault_sticky", 32'(bus.mem_fault), 32'd1);

      // Flush counter saturation
      rst = 1'b1;
      clear_inputs();
      cycle();
      rst = 1'b0;
      bus.ex_mem_branch = 1'b1;
      bus.ex_mem_zero   = 1'b1;
      for (int i = 0; i < 14; i++) cycle();
      check("flush_cnt14", 32'(bus.flush_cnt), 32'd14);
      cycle();
      check("flush_cnt_max", 32'(bus.flush_cnt), 32'd15);
      cycle();
      cycle();
      check("flush_cnt_sat", 32'(bus.flush_cnt), 32'd15);
      check("flush_no_stall", 32'(bus.stall_cnt), 32'd0);

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end
endmodule
